// File: rtl/count4_pkg.sv
// Shared definitions for the count4 sequence code: legal code table, checker
// state encoding and the code-to-index decode function.
package count4_pkg;

    localparam logic [3:0] C0 = 4'b0000;
    localparam logic [3:0] C1 = 4'b1101;
    localparam logic [3:0] C2 = 4'b1010;
    localparam logic [3:0] C3 = 4'b0001;
    localparam logic [3:0] C4 = 4'b1111;
    localparam logic [3:0] C5 = 4'b0010;
    localparam logic [3:0] C6 = 4'b0101;
    localparam logic [3:0] C7 = 4'b1110;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Returns {legal, idx[2:0]}; illegal codes decode to {0, 3'd0}.
    function automatic logic [3:0] code2idx(input logic [3:0] code);
        logic [3:0] res;
        case (code)
            C0:      res = {1'b1, 3'd0};
            C1:      res = {1'b1, 3'd1};
            C2:      res = {1'b1, 3'd2};
            C3:      res = {1'b1, 3'd3};
            C4:      res = {1'b1, 3'd4};
            C5:      res = {1'b1, 3'd5};
            C6:      res = {1'b1, 3'd6};
            C7:      res = {1'b1, 3'd7};
            default: res = {1'b0, 3'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/count4_code_dec.sv
// Combinational decoder from a raw count4 code to its legal flag and
// sequence index.
module count4_code_dec
    import count4_pkg::*;
(
    input  logic [3:0] code_in,
    output logic       legal,
    output logic [2:0] idx
);

    assign {legal, idx} = code2idx(code_in);

endmodule

// File: rtl/count4_seq_checker.sv
// Receive-side lock checker for the count4 code: decodes each accepted sample,
// tracks lock to the expected order and counts sequence errors.
module count4_seq_checker
    import count4_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [3:0]       code_in,
    input  logic             code_vld,
    input  logic             err_clr,
    output logic [2:0]       idx,
    output logic             idx_vld,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

    state_t           state, state_d;
    logic [2:0]       prev, prev_d;
    logic             have_prev, have_prev_d;
    logic [3:0]       good_cnt, good_d;
    logic [3:0]       bad_cnt, bad_d;
    logic [2:0]       idx_d;
    logic             idx_vld_d, illegal_d, seq_err_d;
    logic [ERR_W-1:0] err_d;

    logic             legal;
    logic [2:0]       dec_idx;
    logic [2:0]       prev_inc;
    logic             in_order;
    logic [3:0]       good_inc;
    logic [3:0]       bad_inc;

    count4_code_dec u_dec (
        .code_in (code_in),
        .legal   (legal),
        .idx     (dec_idx)
    );

    assign prev_inc = prev + 3'd1;
    assign in_order = legal && (dec_idx == prev_inc);
    assign good_inc = good_cnt + 4'd1;
    assign bad_inc  = bad_cnt + 4'd1;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= HUNT;
            prev      <= 3'd0;
            have_prev <= 1'b0;
            good_cnt  <= 4'd0;
            bad_cnt   <= 4'd0;
            idx       <= 3'd0;
            idx_vld   <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            prev      <= prev_d;
            have_prev <= have_prev_d;
            good_cnt  <= good_d;
            bad_cnt   <= bad_d;
            idx       <= idx_d;
            idx_vld   <= idx_vld_d;
            illegal   <= illegal_d;
            seq_err   <= seq_err_d;
            err_cnt   <= err_d;
        end
    end

    assign locked = (state == LOCKED);

    always_comb begin
        state_d     = state;
        prev_d      = prev;
        have_prev_d = have_prev;
        good_d      = good_cnt;
        bad_d       = bad_cnt;
        idx_d       = idx;
        idx_vld_d   = 1'b0;
        illegal_d   = 1'b0;
        seq_err_d   = 1'b0;

        if (code_vld) begin
            if (legal) begin
                idx_d     = dec_idx;
                idx_vld_d = 1'b1;
            end else begin
                illegal_d = 1'b1;
            end

            case (state)
                HUNT: begin
                    if (legal) begin
                        prev_d      = dec_idx;
                        have_prev_d = 1'b1;
                        if (have_prev && in_order) begin
                            good_d = good_inc;
                            if (good_inc == LOCK_TGT) begin
                                state_d = LOCKED;
                                bad_d   = 4'd0;
                            end
                        end else begin
                            good_d = 4'd0;
                        end
                    end else begin
                        good_d      = 4'd0;
                        have_prev_d = 1'b0;
                    end
                end
                LOCKED: begin
                    if (in_order) begin
                        prev_d = dec_idx;
                        bad_d  = 4'd0;
                    end else begin
                        // Legal-but-wrong resyncs to the received index; an
                        // illegal code free-wheels so one glitch costs one error.
                        seq_err_d = 1'b1;
                        bad_d     = bad_inc;
                        prev_d    = legal ? dec_idx : prev_inc;
                        if (bad_inc == LOSS_TGT) begin
                            state_d     = HUNT;
                            have_prev_d = 1'b0;
                            good_d      = 4'd0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        err_d = err_cnt;
        if (err_clr) begin
            err_d = seq_err_d ? ERR_W'(1) : '0;
        end else if (seq_err_d && (err_cnt != '1)) begin
            err_d = err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_count4_seq_checker.sv
// Directed-vector bench for count4_seq_checker; a second instance with a
// 2-bit error counter shares the stimulus to exercise saturation.
module tb_count4_seq_checker;
    import count4_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [3:0] code_in = 4'd0;
    logic       code_vld = 1'b0;
    logic       err_clr = 1'b0;

    logic [2:0] idx;
    logic       idx_vld, illegal, seq_err, locked;
    logic [7:0] err_cnt;

    logic [2:0] s_idx;
    logic       s_idx_vld, s_illegal, s_seq_err, s_locked;
    logic [1:0] s_err_cnt;

    logic [16:0] obs;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic        rst_n;
        logic [3:0]  code;
        logic        vld;
        logic        clr;
        logic [16:0] exp;
    } vec_t;

    count4_seq_checker dut (
        .Clk(Clk), .Rst(Rst), .code_in(code_in), .code_vld(code_vld),
        .err_clr(err_clr), .idx(idx), .idx_vld(idx_vld), .illegal(illegal),
        .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
    );

    count4_seq_checker #(.ERR_W(2)) dut_sat (
        .Clk(Clk), .Rst(Rst), .code_in(code_in), .code_vld(code_vld),
        .err_clr(err_clr), .idx(s_idx), .idx_vld(s_idx_vld), .illegal(s_illegal),
        .seq_err(s_seq_err), .locked(s_locked), .err_cnt(s_err_cnt)
    );

    always #5 Clk = ~Clk;

    // The saturating instance sees identical stimulus, so only its counter differs.
    assign obs = {locked, idx_vld, illegal, seq_err, idx, err_cnt, s_err_cnt};

    function automatic vec_t mk(input logic r, input logic [3:0] c, input logic v,
                                input logic e, input logic lk, input logic iv,
                                input logic il, input logic se, input logic [2:0] ix,
                                input logic [7:0] ec, input logic [1:0] es);
        vec_t t;
        t.rst_n = r;
        t.code  = c;
        t.vld   = v;
        t.clr   = e;
        t.exp   = {lk, iv, il, se, ix, ec, es};
        return t;
    endfunction

    task automatic drive(input logic r, input logic [3:0] c, input logic v, input logic e);
        Rst      = r;
        code_in  = c;
        code_vld = v;
        err_clr  = e;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t t[$];
        t.push_back(mk(0, C0,      1, 0, 0, 0, 0, 0, 3'd0, 8'd0, 2'd0));
        t.push_back(mk(0, 4'b0011, 1, 1, 0, 0, 0, 0, 3'd0, 8'd0, 2'd0));
        foreach (t[i]) begin
            drive(t[i].rst_n, t[i].code, t[i].vld, t[i].clr);
            n_vec++;
            if (obs !== t[i].exp) begin
                n_miss++;
                $display("[TB] FAIL reset[%0d]: got %h want %h", i, obs, t[i].exp);
            end
        end
    endtask

    task automatic test_lock_acquire();
        vec_t t[$];
        t.push_back(mk(1, C0, 1, 0, 0, 1, 0, 0, 3'd0, 8'd0, 2'd0));
        t.push_back(mk(1, C1, 1, 0, 0, 1, 0, 0, 3'd1, 8'd0, 2'd0));
        t.push_back(mk(1, C2, 1, 0, 0, 1, 0, 0, 3'd2, 8'd0, 2'd0));
        t.push_back(mk(1, C3, 1, 0, 0, 1, 0, 0, 3'd3, 8'd0, 2'd0));
        t.push_back(mk(1, C4, 1, 0, 1, 1, 0, 0, 3'd4, 8'd0, 2'd0));
        foreach (t[i]) begin
            drive(t[i].rst_n, t[i].code, t[i].vld, t[i].clr);
            n_vec++;
            if (obs !== t[i].exp) begin
                n_miss++;
                $display("[TB] FAIL lock_acquire[%0d]: got %h want %h", i, obs, t[i].exp);
            end
        end
    endtask

    task automatic test_skip();
        vec_t t[$];
        t.push_back(mk(1, C5, 1, 0, 1, 1, 0, 0, 3'd5, 8'd0, 2'd0));
        t.push_back(mk(1, C7, 1, 0, 1, 1, 0, 1, 3'd7, 8'd1, 2'd1));
        t.push_back(mk(1, C0, 1, 0, 1, 1, 0, 0, 3'd0, 8'd1, 2'd1));
        foreach (t[i]) begin
            drive(t[i].rst_n, t[i].code, t[i].vld, t[i].clr);
            n_vec++;
            if (obs !== t[i].exp) begin
                n_miss++;
                $display("[TB] FAIL skip[%0d]: got %h want %h", i, obs, t[i].exp);
            end
        end
    endtask

    task automatic test_illegal();
        vec_t t[$];
        t.push_back(mk(1, C1,      1, 0, 1, 1, 0, 0, 3'd1, 8'd1, 2'd1));
        t.push_back(mk(1, C2,      1, 0, 1, 1, 0, 0, 3'd2, 8'd1, 2'd1));
        t.push_back(mk(1, C3,      1, 0, 1, 1, 0, 0, 3'd3, 8'd1, 2'd1));
        t.push_back(mk(1, 4'b0011, 1, 0, 1, 0, 1, 1, 3'd3, 8'd2, 2'd2));
        t.push_back(mk(1, C5,      1, 0, 1, 1, 0, 0, 3'd5, 8'd2, 2'd2));
        foreach (t[i]) begin
            drive(t[i].rst_n, t[i].code, t[i].vld, t[i].clr);
            n_vec++;
            if (obs !== t[i].exp) begin
                n_miss++;
                $display("[TB] FAIL illegal[%0d]: got %h want %h", i, obs, t[i].exp);
            end
        end
    endtask

    task automatic test_gaps();
        vec_t t[$];
        t.push_back(mk(1, 4'b0011, 0, 0, 1, 0, 0, 0, 3'd5, 8'd2, 2'd2));
        t.push_back(mk(1, C1,      0, 0, 1, 0, 0, 0, 3'd5, 8'd2, 2'd2));
        t.push_back(mk(1, C6,      1, 0, 1, 1, 0, 0, 3'd6, 8'd2, 2'd2));
        t.push_back(mk(1, C7,      1, 0, 1, 1, 0, 0, 3'd7, 8'd2, 2'd2));
        foreach (t[i]) begin
            drive(t[i].rst_n, t[i].code, t[i].vld, t[i].clr);
            n_vec++;
            if (obs !== t[i].exp) begin
                n_miss++;
                $display("[TB] FAIL gaps[%0d]: got %h want %h", i, obs, t[i].exp);
            end
        end
    endtask

    task automatic test_rst_glitch();
        logic [16:0] want;
        code_vld = 1'b0;
        Rst = 1'b0;
        #2;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        want = {1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 8'd2, 2'd2};
        n_vec++;
        if (obs !== want) begin
            n_miss++;
            $display("[TB] FAIL rst_glitch_hold: got %h want %h", obs, want);
        end
        drive(1, C0, 1, 0);
        want = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd2, 2'd2};
        n_vec++;
        if (obs !== want) begin
            n_miss++;
            $display("[TB] FAIL rst_glitch_next: got %h want %h", obs, want);
        end
    endtask

    task automatic test_loss_relock();
        vec_t t[$];
        t.push_back(mk(1, C0,      0, 1, 1, 0, 0, 0, 3'd0, 8'd0, 2'd0));
        t.push_back(mk(1, 4'b0011, 1, 0, 1, 0, 1, 1, 3'd0, 8'd1, 2'd1));
        t.push_back(mk(1, 4'b0100, 1, 0, 1, 0, 1, 1, 3'd0, 8'd2, 2'd2));
        t.push_back(mk(1, 4'b0110, 1, 0, 0, 0, 1, 1, 3'd0, 8'd3, 2'd3));
        t.push_back(mk(1, C4,      1, 0, 0, 1, 0, 0, 3'd4, 8'd3, 2'd3));
        t.push_back(mk(1, C5,      1, 0, 0, 1, 0, 0, 3'd5, 8'd3, 2'd3));
        t.push_back(mk(1, C6,      1, 0, 0, 1, 0, 0, 3'd6, 8'd3, 2'd3));
        t.push_back(mk(1, C7,      1, 0, 0, 1, 0, 0, 3'd7, 8'd3, 2'd3));
        t.push_back(mk(1, C0,      1, 0, 1, 1, 0, 0, 3'd0, 8'd3, 2'd3));
        foreach (t[i]) begin
            drive(t[i].rst_n, t[i].code, t[i].vld, t[i].clr);
            n_vec++;
            if (obs !== t[i].exp) begin
                n_miss++;
                $display("[TB] FAIL loss_relock[%0d]: got %h want %h", i, obs, t[i].exp);
            end
        end
    endtask

    task automatic test_saturation();
        vec_t t[$];
        t.push_back(mk(1, C0, 0, 1, 1, 0, 0, 0, 3'd0, 8'd0, 2'd0));
        t.push_back(mk(1, C0, 1, 0, 1, 1, 0, 1, 3'd0, 8'd1, 2'd1));
        t.push_back(mk(1, C0, 1, 0, 1, 1, 0, 1, 3'd0, 8'd2, 2'd2));
        t.push_back(mk(1, C1, 1, 0, 1, 1, 0, 0, 3'd1, 8'd2, 2'd2));
        t.push_back(mk(1, C1, 1, 0, 1, 1, 0, 1, 3'd1, 8'd3, 2'd3));
        t.push_back(mk(1, C1, 1, 0, 1, 1, 0, 1, 3'd1, 8'd4, 2'd3));
        t.push_back(mk(1, C2, 1, 0, 1, 1, 0, 0, 3'd2, 8'd4, 2'd3));
        t.push_back(mk(1, C4, 1, 0, 1, 1, 0, 1, 3'd4, 8'd5, 2'd3));
        t.push_back(mk(1, C4, 1, 1, 1, 1, 0, 1, 3'd4, 8'd1, 2'd1));
        t.push_back(mk(1, C5, 1, 0, 1, 1, 0, 0, 3'd5, 8'd1, 2'd1));
        foreach (t[i]) begin
            drive(t[i].rst_n, t[i].code, t[i].vld, t[i].clr);
            n_vec++;
            if (obs !== t[i].exp) begin
                n_miss++;
                $display("[TB] FAIL saturation[%0d]: got %h want %h", i, obs, t[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t t[$];
        t.push_back(mk(0, C6,      1, 0, 0, 0, 0, 0, 3'd0, 8'd0, 2'd0));
        t.push_back(mk(1, C7,      1, 0, 0, 1, 0, 0, 3'd7, 8'd0, 2'd0));
        t.push_back(mk(1, C2,      1, 0, 0, 1, 0, 0, 3'd2, 8'd0, 2'd0));
        t.push_back(mk(1, C3,      1, 0, 0, 1, 0, 0, 3'd3, 8'd0, 2'd0));
        t.push_back(mk(1, 4'b1000, 1, 0, 0, 0, 1, 0, 3'd3, 8'd0, 2'd0));
        foreach (t[i]) begin
            drive(t[i].rst_n, t[i].code, t[i].vld, t[i].clr);
            n_vec++;
            if (obs !== t[i].exp) begin
                n_miss++;
                $display("[TB] FAIL reset_mid[%0d]: got %h want %h", i, obs, t[i].exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_skip();
        test_illegal();
        test_gaps();
        test_rst_glitch();
        test_loss_relock();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
